// File: rtl/fft_pkg.sv
// Shared FFT definitions: point count, sample field layout, bit-reversal helper.
package fft_pkg;

  localparam int unsigned FFT_N      = 4;
  localparam int unsigned NUM_STAGES = $clog2(FFT_N);
  localparam int unsigned SAMPLE_W   = 16;

  // Complex sample layout: real in the low half, imag in the high half.
  localparam int unsigned RE_LSB = 0;
  localparam int unsigned RE_MSB = SAMPLE_W / 2 - 1;
  localparam int unsigned IM_LSB = SAMPLE_W / 2;
  localparam int unsigned IM_MSB = SAMPLE_W - 1;

  // Reverse the low nbits of idx; bits above nbits are ignored.
  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned nbits);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < 32; b++) begin
      if (b < nbits) r = (r << 1) | ((idx >> b) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_stream_ctrl_if.sv
// Valid/ready sample stream; index carries the natural bin number on the output side.
interface fft_stream_ctrl_if #(
  parameter int W  = 16,
  parameter int IW = 2
);
  logic          valid;
  logic          ready;
  logic          last;
  logic [W-1:0]  data;
  logic [IW-1:0] index;

  modport master (output valid, data, last, index, input ready);
  modport slave  (input valid, data, last, index, output ready);
endinterface

// File: rtl/fft_out_serializer.sv
// Captures the core result frame and drains it one bin per handshake, optionally
// undoing the core's bit-reversed ordering.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int unsigned N            = FFT_N,
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_W,
  parameter bit          BITREV       = 1'b1
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      frame_full,
  input  logic [N*SAMPLE_WIDTH-1:0] frame_data,
  output logic                      take,
  fft_stream_ctrl_if.master         m_if,
  output logic [15:0]               frame_cnt
);

  localparam int unsigned IDXW = $clog2(N);

  logic [N*SAMPLE_WIDTH-1:0] out_buf;
  logic [IDXW-1:0]           out_idx;
  logic [IDXW-1:0]           rd_idx;
  logic                      out_busy;
  logic                      hs;
  logic                      at_last;

  assign at_last = (out_idx == IDXW'(N - 1));
  assign hs      = out_busy && m_if.ready;
  // A waiting frame may replace the current one on its final handshake, so frames chain without a bubble.
  assign take    = frame_full && (!out_busy || (hs && at_last));

  // Map the natural bin index onto the buffer slot holding it.
  always_comb begin
    rd_idx = out_idx;
    if (BITREV) rd_idx = IDXW'(bitrev(32'(out_idx), IDXW));
  end

  assign m_if.valid = out_busy;
  assign m_if.index = out_idx;
  assign m_if.last  = at_last;
  assign m_if.data  = out_buf[rd_idx*SAMPLE_WIDTH +: SAMPLE_WIDTH];

  // Output buffer capture, bin pointer and completed-frame counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_buf   <= '0;
      out_idx   <= '0;
      out_busy  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (take) begin
        out_buf  <= frame_data;
        out_busy <= 1'b1;
        out_idx  <= '0;
      end else if (hs) begin
        out_idx <= out_idx + 1'b1;
        if (at_last) out_busy <= 1'b0;
      end
      if (hs && at_last) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/fft_stream_ctrl.sv
// Streaming frame controller around a combinational N-point FFT core: collects
// serial samples into a parallel frame and hands the result to the serializer.
module fft_stream_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned N            = FFT_N,
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_W,
  parameter bit          BITREV       = 1'b1
) (
  input  logic                      clk,
  input  logic                      arst_n,
  fft_stream_ctrl_if.slave          s_if,
  fft_stream_ctrl_if.master         m_if,
  output logic [N*SAMPLE_WIDTH-1:0] fft_data_in,
  input  logic [N*SAMPLE_WIDTH-1:0] fft_data_out,
  output logic                      frame_err,
  output logic [15:0]               frame_cnt
);

  localparam int unsigned IDXW = $clog2(N);

  logic [IDXW-1:0] in_cnt;
  logic            in_full;
  logic            accept;
  logic            take;

  assign s_if.ready = !in_full;
  assign accept     = s_if.valid && !in_full;

  // Input collector: fill slots in order; a full frame waits until the serializer takes it.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      in_cnt      <= '0;
      in_full     <= 1'b0;
      frame_err   <= 1'b0;
      fft_data_in <= '0;
    end else begin
      frame_err <= 1'b0;
      if (accept) begin
        fft_data_in[in_cnt*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= s_if.data;
        if (in_cnt == IDXW'(N - 1)) begin
          in_full <= 1'b1;
          in_cnt  <= '0;
        end else if (s_if.last) begin
          in_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          in_cnt <= in_cnt + 1'b1;
        end
      end
      if (take) in_full <= 1'b0;
    end
  end

  fft_out_serializer #(
    .N            (N),
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .BITREV       (BITREV)
  ) u_ser (
    .clk        (clk),
    .arst_n     (arst_n),
    .frame_full (in_full),
    .frame_data (fft_data_out),
    .take       (take),
    .m_if       (m_if),
    .frame_cnt  (frame_cnt)
  );

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Bench for fft_stream_ctrl with an N=4 DFT core model and a bin-order scoreboard.
module tb_fft_stream_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [63:0] fft_data_in;
  logic [63:0] fft_data_out;
  logic        frame_err;
  logic [15:0] frame_cnt;

  bit core_ident  = 1'b0;
  bit rand_mready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int err_seen = 0;
  int err_exp  = 0;
  int frames_exp = 0;

  logic [15:0] cur[$];
  logic [15:0] exp_q[$];
  logic [1:0]  idx_q[$];

  fft_stream_ctrl_if #(.W(16), .IW(2)) s_if ();
  fft_stream_ctrl_if #(.W(16), .IW(2)) m_if ();

  fft_stream_ctrl #(.N(4), .SAMPLE_WIDTH(16), .BITREV(1'b1)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .s_if         (s_if),
    .m_if         (m_if),
    .fft_data_in  (fft_data_in),
    .fft_data_out (fft_data_out),
    .frame_err    (frame_err),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  // 4-point DFT bin k with 8-bit wrapping real/imag parts; twiddles are powers of -j.
  function automatic logic [15:0] dft_bin(input logic [63:0] f, input int k);
    int re, im, a, b;
    logic [7:0] xr, xi;
    re = 0;
    im = 0;
    for (int n = 0; n < 4; n++) begin
      xr = f[n*16 +: 8];
      xi = f[n*16 + 8 +: 8];
      a = int'(xr);
      b = int'(xi);
      case ((n * k) % 4)
        0: begin re += a; im += b; end
        1: begin re += b; im -= a; end
        2: begin re -= a; im -= b; end
        default: begin re -= b; im += a; end
      endcase
    end
    return {im[7:0], re[7:0]};
  endfunction

  // Core model: DFT emitted in bit-reversed order, or a pass-through stub.
  always_comb begin
    fft_data_out = '0;
    for (int k = 0; k < 4; k++) begin
      if (core_ident) fft_data_out[k*16 +: 16] = fft_data_in[k*16 +: 16];
      else            fft_data_out[k*16 +: 16] = dft_bin(fft_data_in, ((k & 1) << 1) | (k >> 1));
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every output handshake must match the next expected bin.
  always @(negedge clk) begin
    logic [15:0] d;
    logic [1:0]  i;
    if (arst_n) begin
      if (frame_err) err_seen++;
      if (m_if.valid && m_if.ready) begin
        check("bin_pending", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          d = exp_q.pop_front();
          i = idx_q.pop_front();
          check("m_data", m_if.data, d);
          check("m_index", m_if.index, i);
          check("m_last", m_if.last, i == 2'd3);
        end
      end
    end
  end

  // Reference: frames are 4 accepted samples; an early last drops the partial frame.
  task automatic model_accept(input logic [15:0] d, input logic l);
    logic [63:0] f;
    cur.push_back(d);
    if (cur.size() == 4) begin
      f = {cur[3], cur[2], cur[1], cur[0]};
      for (int i = 0; i < 4; i++) begin
        if (core_ident) exp_q.push_back(cur[((i & 1) << 1) | (i >> 1)]);
        else            exp_q.push_back(dft_bin(f, i));
        idx_q.push_back(2'(i));
      end
      frames_exp++;
      cur.delete();
    end else if (l) begin
      err_exp++;
      cur.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mready) m_if.ready = ($urandom_range(3) != 0);
  endtask

  task automatic send_sample(input logic [15:0] d, input logic l, input bit gaps);
    logic rdy;
    logic acc;
    if (gaps && $urandom_range(3) == 0) tick();
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.last  = l;
    acc = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      rdy = s_if.ready;
      tick();
      acc = rdy;
    end
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    check("s_accept", acc, 1);
    if (acc) model_accept(d, l);
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < 4; i++) send_sample(16'($urandom), i == 3, gaps);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      if (exp_q.size() == 0 && !m_if.valid) done = 1'b1;
      else tick();
    end
    check("drain_done", 64'(exp_q.size() == 0 && !m_if.valid), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] smp[4];
    logic [15:0] hold_d;
    logic [1:0]  hold_i;

    arst_n      = 1'b0;
    s_if.valid  = 1'b0;
    s_if.data   = '0;
    s_if.last   = 1'b0;
    s_if.index  = '0;
    m_if.ready  = 1'b0;
    tick();
    tick();
    check("rst_s_ready", s_if.ready, 1);
    check("rst_m_valid", m_if.valid, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_fft_data_in", fft_data_in, 0);
    check("rst_m_index", m_if.index, 0);
    arst_n = 1'b1;
    tick();

    // Reorder with identity core, plus 2-cycle latency from last input to first bin.
    core_ident = 1'b1;
    m_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) smp[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) send_sample(smp[i], i == 3, 1'b0);
    check("frame_slots", fft_data_in, {smp[3], smp[2], smp[1], smp[0]});
    check("lat_valid_t", m_if.valid, 0);
    check("lat_stall", s_if.ready, 0);
    tick();
    check("lat_valid_t1", m_if.valid, 1);
    check("lat_index0", m_if.index, 0);
    drain();
    check("cnt_reorder", frame_cnt, 16'(frames_exp));

    // Impulse and DC through the DFT core model.
    core_ident = 1'b0;
    send_sample(16'h0001, 1'b0, 1'b0);
    send_sample(16'h0000, 1'b0, 1'b0);
    send_sample(16'h0000, 1'b0, 1'b0);
    send_sample(16'h0000, 1'b1, 1'b0);
    tick();
    check("impulse_bin0", m_if.data, 16'h0001);
    drain();
    check("cnt_impulse", frame_cnt, 16'(frames_exp));
    for (int i = 0; i < 4; i++) send_sample(16'h0001, i == 3, 1'b0);
    tick();
    check("dc_bin0", m_if.data, 16'h0004);
    drain();
    check("cnt_dc", frame_cnt, 16'(frames_exp));

    // Early last on the 2nd sample drops the frame and pulses frame_err once.
    send_sample(16'($urandom), 1'b0, 1'b0);
    send_sample(16'($urandom), 1'b1, 1'b0);
    check("err_pulse", frame_err, 1);
    tick();
    check("err_one_cycle", frame_err, 0);
    check("err_no_output", m_if.valid, 0);
    send_frame(1'b0);
    drain();
    check("cnt_after_err", frame_cnt, 16'(frames_exp));

    // Backpressure: two frames queue up, input stalls, output holds, then 8 bins back to back.
    m_if.ready = 1'b0;
    send_frame(1'b0);
    send_frame(1'b0);
    check("bp_s_ready", s_if.ready, 0);
    check("bp_m_valid", m_if.valid, 1);
    hold_d = m_if.data;
    hold_i = m_if.index;
    repeat (10) tick();
    check("bp_hold_data", m_if.data, hold_d);
    check("bp_hold_index", m_if.index, hold_i);
    check("bp_still_stalled", s_if.ready, 0);
    m_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("bp_no_gap", m_if.valid, 1);
      tick();
    end
    check("bp_idle", m_if.valid, 0);
    check("cnt_bp", frame_cnt, 16'(frames_exp));

    // Randomized frames, input gaps and consumer stalls.
    rand_mready = 1'b1;
    for (int f = 0; f < 20; f++) send_frame(1'b1);
    drain();
    rand_mready = 1'b0;
    m_if.ready  = 1'b1;
    check("cnt_random", frame_cnt, 16'(frames_exp));

    // Reset mid-drain loses the frame silently.
    m_if.ready = 1'b0;
    send_frame(1'b0);
    tick();
    check("pre_rst_valid", m_if.valid, 1);
    arst_n = 1'b0;
    #1;
    check("mid_rst_valid", m_if.valid, 0);
    check("mid_rst_cnt", frame_cnt, 0);
    check("mid_rst_s_ready", s_if.ready, 1);
    exp_q.delete();
    idx_q.delete();
    cur.delete();
    frames_exp = 0;
    tick();
    arst_n = 1'b1;
    m_if.ready = 1'b1;
    tick();
    send_frame(1'b0);
    drain();
    check("cnt_post_rst", frame_cnt, 16'(frames_exp));
    check("err_total", 64'(err_seen), 64'(err_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
